// File: rtl/protocore_pkg.sv
// Shared definitions for the step controller: FSM state encoding and the
// debounce window computation.
package protocore_pkg;

  // Controller states; encoding is fixed so other blocks can decode it.
  typedef enum logic [1:0] {
    StPause  = 2'd0,
    StRun    = 2'd1,
    StStep   = 2'd2,
    StHalted = 2'd3
  } state_e;

  // Debounce window in clk cycles, evaluated entirely in 32-bit arithmetic.
  function automatic logic [31:0] debounce_cycles(input logic [31:0] clk_hz,
                                                  input logic [31:0] ms);
    return (clk_hz / 32'd1000) * ms;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, consecutive-cycle debounce and a
// one-cycle press pulse on each settled 0->1 transition. Releases are silent.
module btn_debounce #(
  parameter logic [31:0] DebounceCycles = 32'd2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  logic        sync1_q, sync2_q;
  logic        stable_q, stable_d;
  logic [31:0] cnt_q, cnt_d;
  logic        press_q, press_d;

  // Stable value flips only after the synchronized input has disagreed with it
  // for a full window; any agreeing cycle restarts the window.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = 32'd0;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if ((cnt_q + 32'd1) >= DebounceCycles) begin
        stable_d = sync2_q;
        press_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  // Synchronizer, debounce state and registered press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= 32'd0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/step_controller.sv
// Run/pause/single-step controller for a visualized CPU. Steps are issued on
// rising edges of the slow s_clk. Optional step counter enabled by defining
// STEP_COUNT_EN (adds the step_count port).
module step_controller
  import protocore_pkg::*;
#(
  parameter int unsigned SYS_CLK_SPEED = 100_000_000,
  parameter int unsigned DEBOUNCE_MS   = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_clk,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        halt,
  output logic        step_en,
  output logic        running
`ifdef STEP_COUNT_EN
  ,
  output logic [15:0] step_count
`endif
);

  localparam logic [31:0] DebounceCycles =
    debounce_cycles(32'(SYS_CLK_SPEED), 32'(DEBOUNCE_MS));

  logic   run_press, step_press;
  logic   s_clk_q;
  logic   tick;
  logic   issue;
  state_e state_q, state_d;
  logic   step_en_q, running_q;

  btn_debounce #(
    .DebounceCycles(DebounceCycles)
  ) u_run_btn (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_run),
    .press(run_press)
  );

  btn_debounce #(
    .DebounceCycles(DebounceCycles)
  ) u_step_btn (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_step),
    .press(step_press)
  );

  // s_clk is produced in the clk domain, so a plain edge detect suffices.
  assign tick = s_clk & ~s_clk_q;

  // Next state and step issue; halt overrides everything, then run, step, tick.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    if (halt) begin
      state_d = StHalted;
    end else begin
      case (state_q)
        StPause: begin
          if (run_press)       state_d = StRun;
          else if (step_press) state_d = StStep;
        end
        StRun: begin
          if (run_press) state_d = StPause;
          else if (tick) issue = 1'b1;
        end
        StStep: begin
          if (run_press) begin
            state_d = StPause;
          end else if (tick) begin
            issue   = 1'b1;
            state_d = StPause;
          end
        end
        StHalted: state_d = StPause;
        default:  state_d = StPause;
      endcase
    end
  end

  // State, registered outputs and s_clk history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StPause;
      step_en_q <= 1'b0;
      running_q <= 1'b0;
      s_clk_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_en_q <= issue;
      running_q <= (state_d == StRun);
      s_clk_q   <= s_clk;
    end
  end

  assign step_en = step_en_q;
  assign running = running_q;

`ifdef STEP_COUNT_EN
  logic [15:0] count_q, count_d;

  // Count advances at the end of each step_en cycle; wraps naturally.
  always_comb begin
    count_d = count_q;
    if (step_en_q) count_d = count_q + 16'd1;
  end

  // Step counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 16'd0;
    else        count_q <= count_d;
  end

  assign step_count = count_q;
`endif

endmodule

// File: tb/tb_step_controller.sv
// Self-checking bench for step_controller (DEBOUNCE_CYCLES = 2). Define
// STEP_COUNT_EN to also exercise the step counter and its wrap.
module tb_step_controller;

  localparam int Dc = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_clk = 1'b0;
  logic btn_run = 1'b0;
  logic btn_step = 1'b0;
  logic halt = 1'b0;
  logic step_en;
  logic running;
`ifdef STEP_COUNT_EN
  logic [15:0] step_count;
`endif

  int total = 0;
  int passed = 0;
  int pulses = 0;

  step_controller #(
    .SYS_CLK_SPEED(1000),
    .DEBOUNCE_MS  (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_clk   (s_clk),
    .btn_run (btn_run),
    .btn_step(btn_step),
    .halt    (halt),
    .step_en (step_en),
    .running (running)
`ifdef STEP_COUNT_EN
    ,
    .step_count(step_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {MPause, MRun, MStep, MHalted} mmode_e;
  mmode_e      m_mode;
  bit          m_step_en, m_running, m_sprev;
  logic [15:0] m_count;
  // index 0: run button, 1: step button
  bit          m_seen1[2], m_seen2[2], m_stable[2], m_press[2];
  int          m_diff[2];

  task automatic model_reset();
    m_mode = MPause; m_step_en = 0; m_running = 0; m_sprev = 0; m_count = 0;
    for (int b = 0; b < 2; b++) begin
      m_seen1[b] = 0; m_seen2[b] = 0; m_stable[b] = 0; m_press[b] = 0; m_diff[b] = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        bit tk, iss;
        if (m_step_en) m_count = m_count + 16'd1;
        tk  = s_clk && !m_sprev;
        iss = 0;
        if (halt) m_mode = MHalted;
        else if (m_mode == MHalted) m_mode = MPause;
        else if (m_press[0]) m_mode = (m_mode == MPause) ? MRun : MPause;
        else if (m_press[1] && m_mode == MPause) m_mode = MStep;
        else if (tk && m_mode == MRun) iss = 1;
        else if (tk && m_mode == MStep) begin iss = 1; m_mode = MPause; end
        m_step_en = iss;
        m_running = (m_mode == MRun);
        m_sprev   = s_clk;
        // Buttons: input seen two edges late; settle after Dc disagreeing cycles.
        for (int b = 0; b < 2; b++) begin
          bit raw;
          raw = (b == 0) ? btn_run : btn_step;
          m_press[b] = 0;
          if (m_seen2[b] != m_stable[b]) begin
            m_diff[b]++;
            if (m_diff[b] >= Dc) begin
              m_stable[b] = m_seen2[b];
              m_diff[b]   = 0;
              m_press[b]  = m_stable[b];
            end
          end else begin
            m_diff[b] = 0;
          end
          m_seen2[b] = m_seen1[b];
          m_seen1[b] = raw;
        end
      end
    end
  end

  // Per-cycle compare against the model, plus a pulse tally for directed checks.
  initial begin
    forever begin
      @(negedge clk);
      if (step_en) pulses++;
      if (rst_n) begin
        check("step_en", 32'(step_en), 32'(m_step_en));
        check("running", 32'(running), 32'(m_running));
`ifdef STEP_COUNT_EN
        check("step_count", 32'(step_count), 32'(m_count));
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n, input int low);
    repeat (n) begin
      s_clk = 1'b1; cyc(1);
      s_clk = 1'b0; cyc(low);
    end
  endtask

  task automatic press_run();
    btn_run = 1'b1; cyc(6);
    btn_run = 1'b0; cyc(6);
  endtask

  task automatic press_step();
    btn_step = 1'b1; cyc(6);
    btn_step = 1'b0; cyc(6);
  endtask

  int p;

  initial begin
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Idle: ticks in PAUSE do nothing.
    ticks(5, 3);
    #2;
    check("idle_pulses", 32'(pulses), 32'd0);
    check("idle_running", 32'(running), 32'd0);
`ifdef STEP_COUNT_EN
    check("idle_count", 32'(step_count), 32'd0);
`endif
    @(negedge clk);

    // Run then four s_clk edges.
    p = pulses;
    press_run();
    ticks(4, 3);
    cyc(2);
    #2;
    check("run_pulses", 32'(pulses - p), 32'd4);
    check("run_running", 32'(running), 32'd1);
`ifdef STEP_COUNT_EN
    check("run_count", 32'(step_count), 32'd4);
`endif
    @(negedge clk);

    // Run press lands on the same edge as a tick: pause, no step.
    p = pulses;
    btn_run = 1'b1;
    cyc(4);
    s_clk = 1'b1;
    cyc(1);
    s_clk = 1'b0;
    #2;
    check("coinc_step_en", 32'(step_en), 32'd0);
    check("coinc_running", 32'(running), 32'd0);
    @(negedge clk);
    btn_run = 1'b0;
    cyc(6);
    #2;
    check("coinc_pulses", 32'(pulses - p), 32'd0);
    @(negedge clk);

    // Single step from PAUSE: one pulse for three edges.
    press_step();
    p = pulses;
    ticks(3, 3);
    cyc(2);
    #2;
    check("step_pulses", 32'(pulses - p), 32'd1);
    check("step_running", 32'(running), 32'd0);
    @(negedge clk);

    // Halt while running.
    press_run();
    #2;
    check("pre_halt_running", 32'(running), 32'd1);
    @(negedge clk);
    halt = 1'b1;
    p = pulses;
    ticks(10, 3);
    halt = 1'b0;
    cyc(3);
    ticks(2, 3);
    #2;
    check("halt_pulses", 32'(pulses - p), 32'd0);
    check("halt_running", 32'(running), 32'd0);
    @(negedge clk);

    // One-cycle glitch on btn_run must not start running.
    btn_run = 1'b1; cyc(1);
    btn_run = 1'b0; cyc(8);
    p = pulses;
    ticks(2, 3);
    #2;
    check("glitch_running", 32'(running), 32'd0);
    check("glitch_pulses", 32'(pulses - p), 32'd0);
    @(negedge clk);

    // Reset while a single step is pending drops it.
    btn_step = 1'b1; cyc(6);
    btn_step = 1'b0; cyc(2);
    rst_n = 1'b0; cyc(2);
    rst_n = 1'b1; cyc(4);
    p = pulses;
    ticks(3, 3);
    #2;
    check("midreset_pulses", 32'(pulses - p), 32'd0);
    check("midreset_running", 32'(running), 32'd0);
    @(negedge clk);

`ifdef STEP_COUNT_EN
    // Counter wraps after 65536 steps.
    rst_n = 1'b0; cyc(2);
    rst_n = 1'b1; cyc(2);
    press_run();
    p = pulses;
    ticks(65536, 1);
    cyc(3);
    press_run();
    #2;
    check("wrap_pulses", 32'(pulses - p), 32'd65536);
    check("wrap_count", 32'(step_count), 32'd0);
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
